spike_vote_classifier: RTL and testbench

- Downstream stage of the two-layer spiking network (Layer1_Layer2); replaces the bench-side spike counting and label logic with RTL.
- For each example it drives the network's reset to clear membrane state, then opens a fixed counting window.
- During the window it counts output spikes per class, then emits the argmax class label through a valid/ready handshake.

---
 rtl/snn_pkg.sv | 20 ++
 rtl/spike_argmax.sv | 26 ++
 rtl/spike_vote_classifier.sv | 136 +++++++++++++
 tb/tb_spike_vote_classifier.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-network readout stage.
package snn_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, DECIDE, HOLD} state_t;

  localparam int DEF_N_CLASSES = 2;
  localparam int DEF_WINDOW    = 15;
  localparam int DEF_CNT_W     = 8;

  // ceil(log2(value)), never less than 1 so single-entry indices still get a bit
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/spike_argmax.sv
// Combinational argmax over flattened per-class spike counts.
// Strict compare while scanning upward, so the lowest index wins a tie.
module spike_argmax
  import snn_pkg::*;
#(
  parameter int N  = DEF_N_CLASSES,
  parameter int W  = DEF_CNT_W,
  parameter int IW = clog2(DEF_N_CLASSES)
) (
  input  logic [N*W-1:0] counts,
  output logic [IW-1:0]  index,
  output logic [W-1:0]   max_value
);

  always_comb begin
    index     = '0;
    max_value = counts[W-1:0];
    for (int i = 1; i < N; i++) begin
      if (counts[i*W +: W] > max_value) begin
        index     = IW'(i);
        max_value = counts[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/spike_vote_classifier.sv
// Per-example readout: resets the network, counts layer-2 spikes over a fixed
// window, then presents the argmax class on a valid/ready handshake.
module spike_vote_classifier
  import snn_pkg::*;
#(
  parameter int N_CLASSES  = DEF_N_CLASSES,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int CLR_CYCLES = 2,
  parameter int LBL_W      = clog2(N_CLASSES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       start_ready,
  input  logic [N_CLASSES-1:0]       spk_in,
  output logic                       net_reset,
  output logic [LBL_W-1:0]           label,
  output logic                       label_valid,
  input  logic                       label_ready,
  output logic [N_CLASSES*CNT_W-1:0] spike_counts,
  output logic [15:0]                examples_done
);

  localparam int CYC_MAX = (WINDOW > CLR_CYCLES) ? WINDOW : CLR_CYCLES;
  localparam int CYC_W   = clog2(CYC_MAX + 1);

  state_t                     state_reg, state_next;
  logic [CYC_W-1:0]           cyc_reg, cyc_next;
  logic                       net_reset_reg;
  logic [LBL_W-1:0]           label_reg;
  logic [N_CLASSES*CNT_W-1:0] counts_out_reg;
  logic [15:0]                done_reg;
  logic [N_CLASSES*CNT_W-1:0] cnt_flat;
  logic [LBL_W-1:0]           win_index;
  logic [CNT_W-1:0]           win_value;
  logic                       accept;
  logic                       handshake;

  assign start_ready   = (state_reg == IDLE);
  assign accept        = start & start_ready;
  assign label_valid   = (state_reg == HOLD);
  assign handshake     = label_valid & label_ready;
  assign net_reset     = net_reset_reg;
  assign label         = label_reg;
  assign spike_counts  = counts_out_reg;
  assign examples_done = done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = CLEAR;
          cyc_next   = '0;
        end
      end
      CLEAR: begin
        if (cyc_reg == CYC_W'(CLR_CYCLES - 1)) begin
          state_next = COUNT;
          cyc_next   = '0;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      COUNT: begin
        if (cyc_reg == CYC_W'(WINDOW - 1)) begin
          state_next = DECIDE;
          cyc_next   = '0;
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      DECIDE:  state_next = HOLD;
      HOLD:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // net_reset follows the next state so it drops on the edge entering COUNT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      net_reset_reg  <= 1'b1;
      label_reg      <= '0;
      counts_out_reg <= '0;
      done_reg       <= '0;
    end else begin
      net_reset_reg <= (state_next != COUNT);
      if (state_reg == DECIDE) begin
        label_reg      <= win_index;
        counts_out_reg <= cnt_flat;
      end
      if (handshake) done_reg <= done_reg + 16'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_class
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (accept) begin
          cnt_reg <= '0;
        end else if (state_reg == COUNT && spk_in[gi] && cnt_reg != {CNT_W{1'b1}}) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  spike_argmax #(
    .N  (N_CLASSES),
    .W  (CNT_W),
    .IW (LBL_W)
  ) u_argmax (
    .counts    (cnt_flat),
    .index     (win_index),
    .max_value (win_value)
  );

endmodule

// File: tb/tb_spike_vote_classifier.sv
// Directed bench: a default-width instance and a 3-bit-counter instance share
// the same stimulus, each checked against hand-computed counts and labels.
module tb_spike_vote_classifier;

  logic        clk;
  logic        reset;
  logic        start;
  logic        label_ready;
  logic [1:0]  spk_in;

  logic        start_ready, net_reset, label, label_valid;
  logic [15:0] spike_counts;
  logic [15:0] examples_done;

  logic        s_start_ready, s_net_reset, s_label, s_label_valid;
  logic [5:0]  s_spike_counts;
  logic [15:0] s_examples_done;

  int checks   = 0;
  int errors   = 0;
  int exp_done = 0;

  spike_vote_classifier dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_ready   (start_ready),
    .spk_in        (spk_in),
    .net_reset     (net_reset),
    .label         (label),
    .label_valid   (label_valid),
    .label_ready   (label_ready),
    .spike_counts  (spike_counts),
    .examples_done (examples_done)
  );

  spike_vote_classifier #(.CNT_W(3)) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_ready   (s_start_ready),
    .spk_in        (spk_in),
    .net_reset     (s_net_reset),
    .label         (s_label),
    .label_valid   (s_label_valid),
    .label_ready   (label_ready),
    .spike_counts  (s_spike_counts),
    .examples_done (s_examples_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge while both DUTs are idle. Window sample j uses win_pat[2j+:2].
  task automatic run_example(input string tag, input logic [1:0] clr_pat, input logic [29:0] win_pat,
                             input int exp_c0, input int exp_c1, input int exp_lbl,
                             input int exp_slbl, input int stall);
    int nr_low;
    int s_c0;
    int s_c1;
    s_c0   = (exp_c0 > 7) ? 7 : exp_c0;
    s_c1   = (exp_c1 > 7) ? 7 : exp_c1;
    nr_low = 0;
    start  = 1'b1;
    spk_in = clr_pat;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (net_reset == 1'b0) nr_low++;
      if (k == 1)  check_value({tag, "/busy"}, start_ready, 0);
      if (k == 18) check_value({tag, "/valid_early"}, label_valid, 0);
      if (k >= 3 && k <= 17) spk_in = win_pat[2*(k-3) +: 2];
      else spk_in = clr_pat;
    end
    check_value({tag, "/net_reset_low_cycles"}, nr_low, 15);
    @(negedge clk);
    check_value({tag, "/valid"}, label_valid, 1);
    check_value({tag, "/label"}, label, exp_lbl);
    check_value({tag, "/c0"}, spike_counts[7:0], exp_c0);
    check_value({tag, "/c1"}, spike_counts[15:8], exp_c1);
    check_value({tag, "/sat_c0"}, s_spike_counts[2:0], s_c0);
    check_value({tag, "/sat_c1"}, s_spike_counts[5:3], s_c1);
    check_value({tag, "/sat_label"}, s_label, exp_slbl);
    for (int s = 0; s < stall; s++) begin
      start = 1'b1;
      @(negedge clk);
      check_value({tag, "/hold_valid"}, label_valid, 1);
      check_value({tag, "/hold_label"}, label, exp_lbl);
      check_value({tag, "/hold_counts"}, spike_counts, (exp_c1 << 8) | exp_c0);
      check_value({tag, "/hold_start_ready"}, start_ready, 0);
    end
    label_ready = 1'b1;
    @(negedge clk);
    exp_done++;
    check_value({tag, "/valid_after_hs"}, label_valid, 0);
    check_value({tag, "/idle_after_hs"}, start_ready, 1);
    check_value({tag, "/done"}, examples_done, exp_done);
    check_value({tag, "/sat_done"}, s_examples_done, exp_done);
    label_ready = 1'b0;
    start       = 1'b0;
    $display("example %s: label=%0d counts=%0d/%0d sat_label=%0d done=%0d",
             tag, label, spike_counts[7:0], spike_counts[15:8], s_label, examples_done);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    label_ready = 1'b0;
    spk_in      = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_value("rst/net_reset", net_reset, 1);
    check_value("rst/label_valid", label_valid, 0);
    check_value("rst/label", label, 0);
    check_value("rst/counts", spike_counts, 0);
    check_value("rst/done", examples_done, 0);
    check_value("rst/start_ready", start_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    run_example("all10",  2'b00, {15{2'b10}}, 0, 15, 1, 1, 0);
    run_example("tie55",  2'b00, {{5{2'b00}}, {5{2'b10}}, {5{2'b01}}}, 5, 5, 0, 0, 0);
    run_example("zero",   2'b00, 30'd0, 0, 0, 0, 0, 0);
    run_example("clrspk", 2'b11, 30'd0, 0, 0, 0, 0, 0);
    run_example("c0wins", 2'b00, {{5{2'b00}}, {6{2'b01}}, {4{2'b11}}}, 10, 4, 0, 0, 10);

    // Abort mid-window after 7 samples; held counts from c0wins must clear.
    start  = 1'b1;
    spk_in = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check_value("abort/net_reset", net_reset, 1);
    check_value("abort/label_valid", label_valid, 0);
    check_value("abort/counts", spike_counts, 0);
    check_value("abort/sat_counts", s_spike_counts, 0);
    check_value("abort/done", examples_done, 0);
    check_value("abort/start_ready", start_ready, 1);
    exp_done = 0;
    $display("example abort: reset at window sample 7, done=%0d", examples_done);
    @(negedge clk);
    reset  = 1'b1;
    spk_in = 2'b00;
    @(negedge clk);

    run_example("all11",   2'b00, {15{2'b11}}, 15, 15, 0, 0, 0);
    run_example("c1by1",   2'b00, {{4{2'b00}}, {5{2'b01}}, {6{2'b10}}}, 5, 6, 1, 1, 0);
    run_example("satflip", 2'b00, {{6{2'b00}}, 2'b10, {8{2'b11}}}, 8, 9, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
